dmux8way16_stream: RTL and testbench

//  Registered 1-to-8 demultiplexer for 16-bit words: the distribution-side counterpart of the 8-way word mux.

---
 rtl/dmux8way16_stream_pkg.sv | 15 +
 rtl/dmux8way16_stream_slot.sv | 43 ++++
 rtl/dmux8way16_stream.sv | 59 +++++
 tb/tb_dmux8way16_stream.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmux8way16_stream_pkg.sv
// Shared constants and helpers for the 8-way word demultiplexer.
// Imported by dmux_slot and dmux8way16_stream.
package dmux_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] sel_t;

    // Bit offset of channel k inside the flattened out_data bus
    function automatic int ch_slice(input int k, input int width = 16);
        return k * width;
    endfunction

endpackage

// File: rtl/dmux8way16_stream_slot.sv
// One-entry holding register for a single demux output channel.
// A load in the same cycle as a drain replaces the word and keeps the slot full.
//
// state   | meaning
// --------+------------------------------------------
// S_EMPTY | no word held, out valid low
// S_FULL  | word held on data_out, waiting for drain
module dmux_slot
    import dmux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid,
    output logic [WIDTH-1:0] data_out
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       state_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
        end else if (load) begin
            state_q <= S_FULL;
            data_q  <= data_in;
        end else if (drain) begin
            state_q <= S_EMPTY;
        end
    end

    assign valid    = (state_q == S_FULL);
    assign data_out = data_q;

endmodule

// File: rtl/dmux8way16_stream.sv
// Registered 1-to-8 stream demultiplexer with a one-entry buffer per channel.
// Define DMUX8_RR_EN to ignore in_sel and distribute words in strict round robin.
module dmux8way16_stream
    import dmux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     in_sel,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [NCH*WIDTH-1:0] out_data
);

    sel_t           dest;
    logic           accept;
    logic [NCH-1:0] slot_valid;

`ifdef DMUX8_RR_EN
    sel_t rr_ptr;

    // Pointer waits on a full, stalled channel rather than skipping it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= rr_ptr + 1'b1;
        end
    end

    assign dest = rr_ptr;
`else
    assign dest = in_sel;
`endif

    assign in_ready = !slot_valid[dest] || out_ready[dest];
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        dmux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (accept && (dest == sel_t'(k))),
            .drain    (slot_valid[k] && out_ready[k]),
            .data_in  (in_data),
            .valid    (slot_valid[k]),
            .data_out (out_data[ch_slice(k, WIDTH) +: WIDTH])
        );
    end

    assign out_valid = slot_valid;

endmodule

// File: tb/tb_dmux8way16_stream.sv
// Self-checking bench for dmux8way16_stream: directed cases plus random traffic
// against a per-channel occupancy model.
module tb_dmux8way16_stream;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic [2:0]   in_sel;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [127:0] out_data;

    int n_checks = 0;
    int n_err    = 0;

    bit          m_full [8];
    logic [15:0] m_data [8];
    int          m_rr;

    dmux8way16_stream #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int m_dest();
`ifdef DMUX8_RR_EN
        return m_rr;
`else
        return int'(in_sel);
`endif
    endfunction

    function automatic bit m_ready();
        int d = m_dest();
        return !m_full[d] || out_ready[d];
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 8; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = 16'h0;
        end
        m_rr = 0;
    endtask

    task automatic model_check();
        logic [7:0]   ev;
        logic [127:0] ed;
        for (int k = 0; k < 8; k++) begin
            ev[k] = m_full[k];
            ed[k*16 +: 16] = m_data[k];
        end
        chk("in_ready", {127'h0, in_ready}, {127'h0, m_ready()});
        chk("out_valid", {120'h0, out_valid}, {120'h0, ev});
        chk("out_data", out_data, ed);
    endtask

    task automatic model_update();
        bit acc;
        int d;
        if (!rst_n) begin
            m_reset();
            return;
        end
        acc = in_valid && m_ready();
        d   = m_dest();
        for (int k = 0; k < 8; k++)
            if (m_full[k] && out_ready[k]) m_full[k] = 1'b0;
        if (acc) begin
            m_full[d] = 1'b1;
            m_data[d] = in_data;
            m_rr      = (m_rr + 1) % 8;
        end
    endtask

    // Called with inputs already driven just after a falling edge
    task automatic step();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [2:0] s, input logic [15:0] d, input logic [7:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_out_valid", {120'h0, out_valid}, 128'h0);
        chk("reset_out_data", out_data, 128'h0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", {127'h0, in_ready}, 128'h1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 8'hFF);
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifndef DMUX8_RR_EN
        // Routing: one word per channel, consumers always ready
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 16'(16'h1111 * (i + 1)), 8'hFF);
            step();
            chk("route_valid", {120'h0, out_valid}, {120'h0, 8'(1 << i)});
            chk("route_data", {112'h0, out_data[i*16 +: 16]}, {112'h0, 16'(16'h1111 * (i + 1))});
        end
        drive(1'b0, 3'd0, 16'h0, 8'hFF);
        step();

        // Backpressure on ch3
        drive(1'b1, 3'd3, 16'hBEEF, 8'hF7);
        #1 chk("bp_first_ready", {127'h0, in_ready}, 128'h1);
        step();
        drive(1'b1, 3'd3, 16'hCAFE, 8'hF7);
        #1 chk("bp_second_ready", {127'h0, in_ready}, 128'h0);
        step();
        chk("bp_hold_data", {112'h0, out_data[48 +: 16]}, {112'h0, 16'hBEEF});
        step();
        chk("bp_hold_data2", {112'h0, out_data[48 +: 16]}, {112'h0, 16'hBEEF});

        // Drain and refill in the same cycle
        drive(1'b1, 3'd3, 16'hCAFE, 8'hFF);
        #1 chk("refill_ready", {127'h0, in_ready}, 128'h1);
        step();
        chk("refill_data", {112'h0, out_data[48 +: 16]}, {112'h0, 16'hCAFE});
        chk("refill_valid", {120'h0, out_valid}, {120'h0, 8'h08});
        drive(1'b0, 3'd0, 16'h0, 8'hFF);
        step();

        // Independence: ch1 stalled, ch6 still accepts
        drive(1'b1, 3'd1, 16'h0101, 8'hFD);
        step();
        drive(1'b1, 3'd6, 16'h0042, 8'hFD);
        #1 chk("indep_ready", {127'h0, in_ready}, 128'h1);
        step();
        chk("indep_valid", {120'h0, out_valid}, {120'h0, 8'h42});
        chk("indep_data6", {112'h0, out_data[96 +: 16]}, {112'h0, 16'h0042});

        // Reset mid-transfer with ch2/ch5 full
        drive(1'b1, 3'd2, 16'h2222, 8'h00);
        step();
        drive(1'b1, 3'd5, 16'h5555, 8'h00);
        step();
        drive(1'b0, 3'd0, 16'h0, 8'h00);
        chk("pre_reset_valid", {120'h0, out_valid}, {120'h0, 8'h66});
        do_reset();
`else
        // Round robin, all consumers ready
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), 16'(16'h0A00 + i), 8'hFF);
            step();
            chk("rr_valid", {120'h0, out_valid}, {120'h0, 8'(1 << (i % 8))});
            chk("rr_data", {112'h0, out_data[(i % 8)*16 +: 16]}, {112'h0, 16'(16'h0A00 + i)});
        end
        drive(1'b0, 3'd0, 16'h0, 8'hFF);
        step();
        do_reset();

        // Round robin stalls on a full ch2 instead of skipping it
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), 16'(16'h0B00 + i), 8'hFB);
            #1 chk("rr_stall_accept", {127'h0, in_ready}, 128'h1);
            step();
        end
        drive(1'b1, 3'd0, 16'h0BFF, 8'hFB);
        #1 chk("rr_stall_ready", {127'h0, in_ready}, 128'h0);
        step();
        chk("rr_ptr_held", {125'h0, dut.rr_ptr}, 128'h2);
        step();
        chk("rr_ptr_held2", {125'h0, dut.rr_ptr}, 128'h2);
        chk("rr_ch2_data", {112'h0, out_data[32 +: 16]}, {112'h0, 16'h0B02});
        drive(1'b0, 3'd0, 16'h0, 8'h00);
        do_reset();
`endif

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] r;
            for (int b = 0; b < 8; b++) r[b] = ($urandom_range(0, 9) < 6);
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom), r);
            step();
        end

        drive(1'b0, 3'd0, 16'h0, 8'h00);
        do_reset();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
